// File: rtl/pclk_freq_monitor.sv
// Purpose: measures the camera pixel clock against mclk over fixed windows and qualifies it.
// Latency: edges reach the accumulator 2 mclk after the sync stage; results/status update 1 mclk after window end.
// Backpressure: none; freq_valid is a one-cycle pulse and status outputs are levels.
//
// Ports:
//   mclk, mreset_n      system clock and async active-low reset
//   pixelclk, preset_n  measured clock and its async active-low reset
//   enable              runs the monitor; low parks it in DISABLED
//   err_clr             clears err_count (wins over a coincident increment)
//   freq_count          edge count of the last completed window
//   freq_valid          one-cycle pulse when freq_count updates
//   pclk_ok             GOOD_WINDOWS consecutive in-range windows seen
//   pclk_lost           last window counted zero edges
//   err_count           saturating count of out-of-range windows
module pclk_freq_monitor #(
    parameter int WINDOW       = 50000,
    parameter int WIN_W        = 16,
    parameter int CNT_W        = 20,
    parameter int LO_LIMIT     = 20000,
    parameter int HI_LIMIT     = 30000,
    parameter int GOOD_WINDOWS = 3
) (
    input  logic             mclk,
    input  logic             mreset_n,
    input  logic             pixelclk,
    input  logic             preset_n,
    input  logic             enable,
    input  logic             err_clr,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             pclk_ok,
    output logic             pclk_lost,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- pixelclk domain: free-running Gray counter only ----------------
    logic [3:0] pix_gray_q;
    logic [3:0] pix_gray_d;

    assign pix_gray_d = bin2gray(gray2bin(pix_gray_q) + 4'd1);

    always_ff @(posedge pixelclk or negedge preset_n) begin
        if (!preset_n) begin
            pix_gray_q <= '0;
        end else begin
            pix_gray_q <= pix_gray_d;
        end
    end

    // ---------------- CDC into mclk ----------------
    logic [3:0] gray_s1_q;
    logic [3:0] gray_s2_q;
    logic [3:0] bin_prev_q;
    logic       prst_s1_q;
    logic       prst_s2_q;
    logic [3:0] bin_now;
    logic [3:0] delta;

    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            gray_s1_q  <= '0;
            gray_s2_q  <= '0;
            prst_s1_q  <= 1'b0;
            prst_s2_q  <= 1'b0;
            bin_prev_q <= '0;
        end else begin
            gray_s1_q  <= pix_gray_q;
            gray_s2_q  <= gray_s1_q;
            prst_s1_q  <= preset_n;
            prst_s2_q  <= prst_s1_q;
            bin_prev_q <= bin_now;
        end
    end

    assign bin_now = gray2bin(gray_s2_q);
    // While the pixel-side reset is seen low, the counter's backward jump to 0 must not
    // be read as a huge modulo-16 step; bin_prev keeps tracking so release is clean.
    assign delta   = prst_s2_q ? (bin_now - bin_prev_q) : 4'd0;

    // ---------------- window accumulation and status FSM ----------------
    state_t           state_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W:0]   acc_sum;
    logic [3:0]       good_q;
    logic [3:0]       good_inc;
    logic             win_end;
    logic             in_range;
    logic [CNT_W-1:0] freq_count_q;
    logic             freq_valid_q;
    logic             pclk_ok_q;
    logic             pclk_lost_q;
    logic [7:0]       err_q;

    assign acc_sum  = {1'b0, acc_q} + {{(CNT_W-3){1'b0}}, delta};
    // Saturate rather than wrap so a wildly fast clock never reads as in range.
    assign acc_d    = acc_sum[CNT_W] ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
    assign win_end  = (win_q == WIN_W'(WINDOW - 1));
    assign in_range = (acc_d >= CNT_W'(LO_LIMIT)) && (acc_d <= CNT_W'(HI_LIMIT));
    assign good_inc = (good_q >= 4'(GOOD_WINDOWS)) ? good_q : good_q + 4'd1;

    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            state_q      <= ST_DISABLED;
            win_q        <= '0;
            acc_q        <= '0;
            good_q       <= '0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            pclk_ok_q    <= 1'b0;
            pclk_lost_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            freq_valid_q <= 1'b0;
            if (!enable) begin
                // Any partial window is thrown away; freq_count and err_count are held.
                state_q     <= ST_DISABLED;
                win_q       <= '0;
                acc_q       <= '0;
                good_q      <= '0;
                pclk_ok_q   <= 1'b0;
                pclk_lost_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_DISABLED: begin
                        state_q <= ST_WARMUP;
                        win_q   <= '0;
                        acc_q   <= '0;
                    end
                    ST_WARMUP, ST_RUN: begin
                        if (win_end) begin
                            win_q <= '0;
                            acc_q <= '0;
                            if (state_q == ST_WARMUP) begin
                                // First window may start mid-edge-stream; discard it.
                                state_q <= ST_RUN;
                            end else begin
                                freq_count_q <= acc_d;
                                freq_valid_q <= 1'b1;
                                pclk_lost_q  <= (acc_d == '0);
                                if (in_range) begin
                                    good_q    <= good_inc;
                                    pclk_ok_q <= (good_inc == 4'(GOOD_WINDOWS));
                                end else begin
                                    good_q    <= '0;
                                    pclk_ok_q <= 1'b0;
                                    if (err_q != 8'hFF) begin
                                        err_q <= err_q + 8'd1;
                                    end
                                end
                            end
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                            acc_q <= acc_d;
                        end
                    end
                    default: begin
                        state_q <= ST_DISABLED;
                    end
                endcase
            end
            // Last assignment wins: a clear coinciding with an increment yields 0.
            if (err_clr) begin
                err_q <= '0;
            end
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = freq_valid_q;
    assign pclk_ok    = pclk_ok_q;
    assign pclk_lost  = pclk_lost_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_pclk_freq_monitor.sv
// Purpose: self-checking bench for pclk_freq_monitor with a time-based edge-count reference.
// Latency: model predicts each result from pixelclk edge timestamps inside the measured window.
// Backpressure: none; stimulus drives levels and the monitor samples on mclk falling edges.
module tb_pclk_freq_monitor;

    localparam int WINDOW = 100;
    localparam int LO     = 45;
    localparam int HI     = 55;
    localparam int GOOD   = 3;
    localparam int CNT_W  = 20;
    localparam int MPER   = 20;   // mclk period

    logic             mclk = 1'b0;
    logic             mreset_n;
    logic             pixelclk;
    logic             preset_n;
    logic             enable;
    logic             err_clr;
    logic [CNT_W-1:0] freq_count;
    logic             freq_valid;
    logic             pclk_ok;
    logic             pclk_lost;
    logic [7:0]       err_count;

    int n_chk = 0;
    int n_err = 0;

    pclk_freq_monitor #(
        .WINDOW(WINDOW), .WIN_W(16), .CNT_W(CNT_W),
        .LO_LIMIT(LO), .HI_LIMIT(HI), .GOOD_WINDOWS(GOOD)
    ) dut (
        .mclk(mclk), .mreset_n(mreset_n), .pixelclk(pixelclk), .preset_n(preset_n),
        .enable(enable), .err_clr(err_clr), .freq_count(freq_count),
        .freq_valid(freq_valid), .pclk_ok(pclk_ok), .pclk_lost(pclk_lost),
        .err_count(err_count)
    );

    always #(MPER/2) mclk = ~mclk;

    // pixelclk: even half periods started at posedge+5 keep every pixel edge on odd
    // times, never coincident with mclk edges or stimulus changes.
    bit pix_run = 1'b0;
    int half    = 20;
    initial begin
        pixelclk = 1'b0;
        forever begin
            if (pix_run) begin
                #(half);
                pixelclk = ~pixelclk;
            end else begin
                @(posedge mclk);
                #5;
            end
        end
    end

    // Timestamps of every rising pixel edge that the counter can see.
    time edge_q[$];
    always @(posedge pixelclk) begin
        if (preset_n) edge_q.push_back($time);
    end

    task automatic check(input string tag, input longint obs, input longint exp, input int tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d > longint'(tol)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at t=%0t", tag, obs, exp, tol, $time);
        end
    endtask

    // Edges counted in a window closing at posedge T are those in (T-102P, T-2P]:
    // two synchronizer stages plus the accumulate edge separate pixel edge from count.
    function automatic int model_count(input time t_close);
        int c;
        c = 0;
        foreach (edge_q[i]) begin
            if (edge_q[i] > t_close - 102*MPER && edge_q[i] <= t_close - 2*MPER) c++;
        end
        return c;
    endfunction

    // ---------------- reference model, evaluated on mclk falling edges ----------------
    bit     en_pend, clr_pend, en_prev, en_app, clr_app, exp_fv, look;
    bit     m_ok, m_lost;
    int     m_good, m_err, m_cnt, m_last_cnt;
    longint ncyc, next_pulse;

    always @(negedge mclk) begin
        if (!mreset_n) begin
            en_pend = 1'b0; clr_pend = 1'b0; en_prev = 1'b0;
            m_ok = 1'b0; m_lost = 1'b0; m_good = 0; m_err = 0; m_last_cnt = 0;
            next_pulse = -1; ncyc = 0;
        end else begin
            ncyc++;
            en_app  = en_pend;
            clr_app = clr_pend;
            look    = clr_app || (en_app != en_prev);
            if (!en_app) begin
                m_ok = 1'b0; m_lost = 1'b0; m_good = 0; next_pulse = -1;
            end else if (!en_prev) begin
                next_pulse = ncyc + 2*WINDOW;   // warm-up window + first measured window
            end
            exp_fv = en_app && (ncyc == next_pulse);
            if (exp_fv) begin
                m_cnt      = model_count($time - MPER/2);
                m_last_cnt = m_cnt;
                next_pulse = ncyc + WINDOW;
                m_lost     = (m_cnt == 0);
                if (m_cnt >= LO && m_cnt <= HI) begin
                    m_good = (m_good < GOOD) ? m_good + 1 : GOOD;
                    m_ok   = (m_good == GOOD);
                end else begin
                    m_good = 0;
                    m_ok   = 1'b0;
                    if (m_err < 255) m_err++;
                end
                while (edge_q.size() > 0 && edge_q[0] < $time - 200*MPER) void'(edge_q.pop_front());
            end
            if (clr_app) m_err = 0;
            if (exp_fv || freq_valid) check("freq_valid", longint'(freq_valid), longint'(exp_fv), 0);
            if (exp_fv) check("freq_count", longint'(freq_count), longint'(m_cnt), 1);
            if (look || exp_fv || freq_valid) begin
                check("pclk_ok", longint'(pclk_ok), longint'(m_ok), 0);
                check("pclk_lost", longint'(pclk_lost), longint'(m_lost), 0);
                check("err_count", longint'(err_count), longint'(m_err), 0);
            end
            en_prev  = en_app;
            en_pend  = enable;
            clr_pend = err_clr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    task automatic wait_pulse(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (freq_valid) break;
        end
        check("pulse_seen", longint'(freq_valid), 1, 0);
    endtask

    initial begin
        #(90000 * MPER);
        $display("FAIL watchdog: run did not complete, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        mreset_n = 1'b0; preset_n = 1'b0; enable = 1'b0; err_clr = 1'b0;
        tick(5);
        check("rst_freq_count", longint'(freq_count), 0, 0);
        check("rst_freq_valid", longint'(freq_valid), 0, 0);
        check("rst_pclk_ok", longint'(pclk_ok), 0, 0);
        check("rst_pclk_lost", longint'(pclk_lost), 0, 0);
        check("rst_err_count", longint'(err_count), 0, 0);
        mreset_n = 1'b1; preset_n = 1'b1;
        half = 20; pix_run = 1'b1;
        tick(10);

        // Nominal mclk/2: qualify after three RUN windows.
        enable = 1'b1;
        for (int k = 0; k < 4; k++) wait_pulse(2*WINDOW + 20);
        check("ok_nominal", longint'(pclk_ok), 1, 0);
        check("err_nominal", longint'(err_count), 0, 0);

        // Stop pixelclk mid-window; the next full window must read zero.
        tick($urandom_range(30, 70));
        pix_run = 1'b0;
        wait_pulse(WINDOW + 20);
        wait_pulse(WINDOW + 20);
        check("stop_count", longint'(freq_count), 0, 0);
        check("stop_lost", longint'(pclk_lost), 1, 0);
        check("stop_ok", longint'(pclk_ok), 0, 0);

        // Restart: lost clears after one window, ok needs three good ones.
        tick($urandom_range(30, 70));
        pix_run = 1'b1;
        wait_pulse(WINDOW + 20);
        wait_pulse(WINDOW + 20);
        check("restart_lost", longint'(pclk_lost), 0, 0);
        check("restart_ok", longint'(pclk_ok), 0, 0);
        for (int k = 0; k < 3; k++) wait_pulse(WINDOW + 20);
        check("restart_requal", longint'(pclk_ok), 1, 0);

        // Too fast (mclk x 1.25): every window is an error.
        half = 8;
        for (int k = 0; k < 4; k++) wait_pulse(WINDOW + 20);
        tick(WINDOW - 1);
        err_clr = 1'b1;                 // lands in the window-end cycle
        tick(1);
        err_clr = 1'b0;
        check("clr_coincide_fv", longint'(freq_valid), 1, 0);
        check("clr_coincide_err", longint'(err_count), 0, 0);
        for (int k = 0; k < 300; k++) wait_pulse(WINDOW + 20);
        check("err_saturated", longint'(err_count), 255, 0);
        check("fast_ok", longint'(pclk_ok), 0, 0);
        check("fast_count", longint'(freq_count), 125, 1);

        // Back to nominal, then drop enable mid-window.
        half = 20;
        for (int k = 0; k < 5; k++) wait_pulse(WINDOW + 20);
        check("nominal_again_ok", longint'(pclk_ok), 1, 0);
        tick($urandom_range(20, 70));
        enable = 1'b0;
        tick(1);
        check("dis_ok", longint'(pclk_ok), 0, 0);
        check("dis_fv", longint'(freq_valid), 0, 0);
        tick(30);
        check("dis_hold_count", longint'(freq_count), longint'(m_last_cnt), 0);
        enable = 1'b1;
        wait_pulse(2*WINDOW + 60);
        wait_pulse(WINDOW + 20);

        // Pixel-side reset for 30 mclk mid-window.
        tick($urandom_range(20, 60));
        preset_n = 1'b0;
        tick(30);
        preset_n = 1'b1;
        wait_pulse(WINDOW + 20);
        check("preset_count", longint'(freq_count), 35, 2);
        wait_pulse(WINDOW + 20);
        check("preset_recover", longint'(freq_count), 50, 1);

        // Asynchronous system reset takes effect without a clock edge.
        tick(10);
        mreset_n = 1'b0;
        #1;
        check("arst_freq_count", longint'(freq_count), 0, 0);
        check("arst_err_count", longint'(err_count), 0, 0);
        check("arst_pclk_ok", longint'(pclk_ok), 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pclk_freq_monitor.md
Name: pclk_freq_monitor

Overview:
- Checks the camera's returned pixel clock (pixelclk) against mclk, the system clock.
- In each fixed window of mclk cycles, it counts pixelclk edges and reports the measured count.
- It flags the clock as good only after several consecutive in-range windows. It flags loss of clock when a window sees no edges.
- It sits beside the clock/reset generator and drives system status and the camera-init sequencer, which waits for pclk_ok.

Parameters:
- WINDOW, 50000: mclk cycles per measurement window (≥ 4).
- WIN_W, 16: width of the window counter; 2^WIN_W > WINDOW.
- CNT_W, 20: width of the edge accumulator and freq_count.
- LO_LIMIT, 20000: minimum in-range count, inclusive.
- HI_LIMIT, 30000: maximum in-range count, inclusive.
- GOOD_WINDOWS, 3: number of consecutive in-range windows before pclk_ok asserts (1..15).

Ports:
- mclk, in, 1: system clock.
- mreset_n, in, 1: system reset, asynchronous, active-low.
- pixelclk, in, 1: measured clock (the camera pixel clock).
- preset_n, in, 1: pixelclk-domain reset, asynchronous, active-low.
- enable, in, 1: runs the monitor (mclk domain).
- err_clr, in, 1: synchronous clear of err_count (mclk domain).
- freq_count, out, CNT_W: edge count of the last completed window.
- freq_valid, out, 1: one-cycle pulse when freq_count updates.
- pclk_ok, out, 1: pixelclk qualified in range.
- pclk_lost, out, 1: last window counted zero edges.
- err_count, out, 8: number of out-of-range windows, saturating.

Behaviour:
- Reset (mreset_n low) sets all mclk-domain flops to 0:
  - freq_count=0, freq_valid=0, pclk_ok=0, pclk_lost=0, err_count=0.
  - FSM goes to DISABLED.
- pixelclk domain:
  - 4-bit Gray counter, increments on every pixelclk rising edge.
  - Asynchronously cleared by preset_n and held at 0 while preset_n is low.
  - No other logic in this domain.
- CDC:
  - The Gray value passes through a 2-flop synchronizer into mclk (both stages reset to 0). It is then converted to binary.
  - delta = bin_now − bin_prev, modulo 16; bin_prev updates every mclk cycle.
  - Valid for pixelclk ≤ 4× mclk.
  - A stalled clock or a clock held in reset gives delta=0.
- Accumulator:
  - acc += delta every mclk cycle while not DISABLED.
  - Saturates at 2^CNT_W−1, with no wrap.
- Window counter:
  - Counts 0..WINDOW−1 and wraps to 0.
  - The cycle where the counter equals WINDOW−1 is the window end.
  - At window end, the closing value is acc plus that cycle's delta (saturated). acc then resets to 0.
- FSM states: DISABLED, WARMUP, RUN.
  - DISABLED: window counter and acc held at 0. Outputs are forced pclk_ok=0, pclk_lost=0, freq_valid=0. freq_count and err_count are held. Moves to WARMUP when enable=1.
  - WARMUP: runs one full window. The result is discarded (no freq_valid, no status update). At the window end it moves to RUN.
  - RUN: at each window end, in the next cycle:
    - freq_count ← closing value, and freq_valid pulses for 1 cycle.
    - pclk_lost ← (value==0).
    - If LO_LIMIT ≤ value ≤ HI_LIMIT: good_cnt increments (saturates at GOOD_WINDOWS), and pclk_ok ← (good_cnt reaches GOOD_WINDOWS).
    - Otherwise: good_cnt←0, pclk_ok←0 in the same update, and err_count increments (saturating at 255).
  - From any state, enable=0 returns to DISABLED on the next cycle; good_cnt clears, and any partial window is discarded.
- err_clr:
  - Clears err_count on the next cycle.
  - If err_clr coincides with an increment, the clear wins (result 0).
- Latency: freq_valid rises 1 mclk after the window-end cycle, i.e. exactly WINDOW cycles apart in RUN.
- preset_n is asserted in the middle of a window: the partial count is kept and no further edges accrue. The window closes normally with a low value.
- The value at preset_n release, which is a backward step of the Gray counter to 0, is treated as bin_prev resync. On that cycle delta is forced to 0 when the synchronized value goes to 0 and sync2_prev ≠ 0 while preset_n-sync reads low.
  - Simplification adopted: the pixelclk-domain preset_n is also passed through a 2-flop synchronizer into mclk. While it is low, delta=0 and bin_prev tracks bin_now.
- mreset_n asserted at any time: immediate asynchronous return to reset values.

Test Plan:
- Bench parameters: WINDOW=100, LO_LIMIT=45, HI_LIMIT=55, GOOD_WINDOWS=3, with pixelclk = mclk/2.
  - Stimulus: enable=1.
  - Required: no freq_valid during WARMUP. freq_valid pulses every 100 cycles with freq_count=50±1. pclk_ok rises on the 3rd RUN pulse. err_count stays 0.
- pixelclk stopped after pclk_ok=1 -> next full window gives freq_count=0, pclk_lost=1, pclk_ok=0, err_count=1. Restarting the clock: pclk_lost=0 after the next window, and pclk_ok only after 3 good windows.
- pixelclk = mclk×1.25 (count ≈125) -> pclk_ok stays 0, and err_count increments once per window. Run 300 windows and require err_count=255, saturated.
- err_clr pulsed in the same cycle as an out-of-range window end -> err_count=0 on the following cycle.
- enable dropped mid-window in RUN -> next cycle DISABLED with pclk_ok=0 and no freq_valid, and freq_count is held. Re-enabling passes through WARMUP again (first pulse 200 cycles later).
- preset_n held low for 30 mclk mid-window, pixelclk = mclk/2 -> that window's count ≈35 gives an out-of-range error. The next window returns 50, with no spurious large count at release.
